// File: rtl/cond_branch_pkg.sv
// Shared encodings for conditional-branch resolution:
// the condition codes and the flag bit positions within {N,Z,C,V}.
package cond_branch_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code evaluator: decides whether
// a 4-bit condition holds for a given {N,Z,C,V} flag set.
module cond_eval
    import cond_branch_pkg::*;
(
    input  logic   [3:0] cond,
    input  flags_t       flags,
    output logic         cond_true
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[FLAG_N];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];
    assign v_flag = flags[FLAG_V];

    // Every code is listed, so the result is never undefined
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z_flag;
            COND_NE: cond_true = !z_flag;
            COND_CS: cond_true = c_flag;
            COND_CC: cond_true = !c_flag;
            COND_MI: cond_true = n_flag;
            COND_PL: cond_true = !n_flag;
            COND_VS: cond_true = v_flag;
            COND_VC: cond_true = !v_flag;
            COND_HI: cond_true = c_flag && !z_flag;
            COND_LS: cond_true = !c_flag || z_flag;
            COND_GE: cond_true = (n_flag == v_flag);
            COND_LT: cond_true = (n_flag != v_flag);
            COND_GT: cond_true = !z_flag && (n_flag == v_flag);
            COND_LE: cond_true = z_flag || (n_flag != v_flag);
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_control.sv
// Execute-stage branch resolution: architectural flags register, flag
// forwarding, next-PC selection and a one-cycle flush on taken branches.
module cond_branch_control
    import cond_branch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [3:0]        flags_in,
    input  logic              flags_we,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc_plus1,
    output logic [3:0]        flags_q,
    output logic              br_taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              flush
);

    logic   flags_wr;
    flags_t eff_flags;
    logic   cond_true;

    assign flags_wr = flags_we && !stall;

    // A branch in the same cycle as a flag write must see the new flags
    assign eff_flags = flags_wr ? flags_in : flags_q;

    cond_eval u_cond_eval (
        .cond      (br_cond),
        .flags     (eff_flags),
        .cond_true (cond_true)
    );

    assign br_taken = br_valid && !stall && cond_true;
    assign next_pc  = br_taken ? br_target : pc_plus1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (flags_wr) begin
            flags_q <= flags_in;
        end
    end

    // Flush follows br_taken by one cycle; stall does not stretch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush <= 1'b0;
        end else begin
            flush <= br_taken;
        end
    end

endmodule

// File: tb/tb_cond_branch_control.sv
// Directed self-checking bench for cond_branch_control: reset, flag
// write/forwarding, stall, back-to-back flushes and all 256 cond/flag pairs.
module tb_cond_branch_control;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic [3:0]        flags_in;
    logic              flags_we;
    logic              br_valid;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_plus1;
    logic [3:0]        flags_q;
    logic              br_taken;
    logic [ADDR_W-1:0] next_pc;
    logic              flush;

    int compare_count;
    int mismatch_count;

    cond_branch_control #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flags_in  (flags_in),
        .flags_we  (flags_we),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_target (br_target),
        .pc_plus1  (pc_plus1),
        .flags_q   (flags_q),
        .br_taken  (br_taken),
        .next_pc   (next_pc),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c,
                                 input logic we, input logic [3:0] f, input logic s);
        br_valid = v;
        br_cond  = c;
        flags_we = we;
        flags_in = f;
        stall    = s;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference built from condition pairs: even code is the base test,
    // odd code is its complement
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        rst_n     = 1'b0;
        br_target = 16'h0000;
        pc_plus1  = 16'h0000;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        #12;
        checkOutput("reset_flags_q", 32'(flags_q), 32'h0);
        checkOutput("reset_flush", 32'(flush), 32'h0);
        rst_n = 1'b1;

        // Taken AL branch with a flag write, then reset mid-cycle
        nextCycle();
        br_target = 16'h1234;
        pc_plus1  = 16'h0001;
        applyStimulus(1'b1, 4'hE, 1'b1, 4'b0100, 1'b0);
        #1;
        checkOutput("al_taken", 32'(br_taken), 32'h1);
        checkOutput("al_next_pc", 32'(next_pc), 32'h1234);
        nextCycle();
        checkOutput("pre_reset_flush", 32'(flush), 32'h1);
        checkOutput("pre_reset_flags", 32'(flags_q), 32'h4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("idle_next_pc", 32'(next_pc), 32'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_flush", 32'(flush), 32'h0);
        checkOutput("async_reset_flags", 32'(flags_q), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        br_target = 16'h0040;
        pc_plus1  = 16'h0011;
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("post_reset_eq_taken", 32'(br_taken), 32'h0);
        checkOutput("post_reset_eq_pc", 32'(next_pc), 32'h0011);

        // Flag write, then EQ branch from the registered flags
        applyStimulus(1'b0, 4'h0, 1'b1, 4'b0100, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("reg_flags_q", 32'(flags_q), 32'h4);
        checkOutput("eq_taken", 32'(br_taken), 32'h1);
        checkOutput("eq_next_pc", 32'(next_pc), 32'h0040);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        checkOutput("eq_flush_high", 32'(flush), 32'h1);
        nextCycle();
        checkOutput("eq_flush_low", 32'(flush), 32'h0);

        // Forwarding: clear flags, then write N in the branch cycle
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
        nextCycle();
        checkOutput("cleared_flags_q", 32'(flags_q), 32'h0);
        applyStimulus(1'b1, 4'h4, 1'b1, 4'b1000, 1'b0);
        #1;
        checkOutput("fwd_mi_taken", 32'(br_taken), 32'h1);
        applyStimulus(1'b1, 4'h5, 1'b1, 4'b1000, 1'b0);
        #1;
        checkOutput("fwd_pl_taken", 32'(br_taken), 32'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        nextCycle();

        // Stall blocks both the flag write and the branch
        applyStimulus(1'b1, 4'hE, 1'b1, 4'b0100, 1'b1);
        #1;
        checkOutput("stall_taken", 32'(br_taken), 32'h0);
        checkOutput("stall_next_pc", 32'(next_pc), 32'h0011);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        checkOutput("stall_flags_q", 32'(flags_q), 32'h0);
        checkOutput("stall_flush", 32'(flush), 32'h0);

        // Named signed cases
        applyStimulus(1'b1, 4'hB, 1'b1, 4'b1000, 1'b0); #1;
        checkOutput("lt_n1_v0", 32'(br_taken), 32'h1);
        applyStimulus(1'b1, 4'hD, 1'b1, 4'b1000, 1'b0); #1;
        checkOutput("le_n1_v0", 32'(br_taken), 32'h1);
        applyStimulus(1'b1, 4'hA, 1'b1, 4'b1001, 1'b0); #1;
        checkOutput("ge_n1_v1", 32'(br_taken), 32'h1);
        applyStimulus(1'b1, 4'hC, 1'b1, 4'b1001, 1'b0); #1;
        checkOutput("gt_n1_v1", 32'(br_taken), 32'h1);

        // Every condition against every flag value, via the forwarding path
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                applyStimulus(1'b1, 4'(c), 1'b1, 4'(f), 1'b0);
                #1;
                checkOutput($sformatf("cond_%0h_flags_%0h", c, f),
                            32'(br_taken), 32'(refCond(4'(c), 4'(f))));
            end
        end

        // br_valid low masks an always-true condition
        applyStimulus(1'b0, 4'hE, 1'b0, 4'h0, 1'b0);
        #1;
        checkOutput("invalid_al_taken", 32'(br_taken), 32'h0);
        checkOutput("invalid_al_pc", 32'(next_pc), 32'h0011);
        nextCycle();
        checkOutput("b2b_pre_flush", 32'(flush), 32'h0);

        // Back-to-back taken branches keep flush high
        applyStimulus(1'b1, 4'hE, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("b2b_flush_%0d", i), 32'(flush), 32'h1);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        nextCycle();
        checkOutput("b2b_flush_end", 32'(flush), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
